// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer states; the encoding is not visible outside the block.
  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } pll_seq_state_t;

  // Width of the lock-loss counter and its saturation value.
  localparam int         RELOCK_W   = 8;
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  // ceil(log2(value)), never less than one bit so a degenerate parameter
  // still yields a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the single shared cycle counter: wide enough for the largest
  // terminal count (max_cycles - 1) among the three timed phases.
  function automatic int CNT_W(input int rst_cycles, input int timeout_cycles,
                               input int stable_cycles);
    int m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return clog2_min1(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop bit synchronizer for an asynchronous level input. All stages
// clear to 0 on reset so the consumer sees "not locked" until real samples
// have propagated through the chain.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain; stage 0 is the only flop that
  // may go metastable, later stages give it time to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer. Holds the PLL in reset, waits for LOCK, demands a
// period of continuous lock, then releases the system reset. Lock loss in
// RUN re-sequences; repeated lock timeouts latch a sticky fault. All
// outputs are registered and computed from the next state, so they change
// on the same edge as the state they describe.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int  PLL_RST_CYCLES      = 16,
  parameter int  LOCK_TIMEOUT_CYCLES = 48000,
  parameter int  LOCK_STABLE_CYCLES  = 4800,
  parameter int  MAX_RETRIES         = 3,
  parameter int  SYNC_STAGES         = 2,
  localparam int RETRY_W             = clog2_min1(MAX_RETRIES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                resequence,
  output logic                pll_rst_n,
  output logic                sys_rst,
  output logic                clk_ready,
  output logic                fault,
  output logic [RETRY_W-1:0]  retry_cnt,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int CNT_WIDTH = CNT_W(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  // Terminal counts for each timed phase (counter runs 0 .. N-1).
  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  pll_seq_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [RELOCK_W-1:0]   relock_q, relock_d;

  logic pll_rst_n_q, pll_rst_n_d;
  logic sys_rst_q, sys_rst_d;
  logic clk_ready_q, clk_ready_d;
  logic fault_q, fault_d;

  logic lock_s;

  // PLL LOCK is asynchronous to clk; only the synchronized copy is used.
  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      pll_rst_n_q <= 1'b0;
      sys_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_rst_n_q <= pll_rst_n_d;
      sys_rst_q   <= sys_rst_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state, phase counter, retry and lock-loss bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = relock_q;

    if (resequence) begin
      // Software restart wins over every FSM transition; the lock-loss
      // history is kept because it is a lifetime statistic.
      state_d = PLL_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = FAULT;
            end else begin
              state_d = PLL_RESET;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        STABILIZE: begin
          // A dropout restarts the lock wait with a fresh timeout but is
          // not treated as a failed attempt.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
            if (relock_q != RELOCK_MAX) begin
              relock_d = relock_q + RELOCK_W'(1);
            end
          end
        end

        FAULT: begin
          // Sticky until rst or resequence.
        end

        default: begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs track state on the same edge.
  always_comb begin
    pll_rst_n_d = 1'b0;
    sys_rst_d   = 1'b1;
    clk_ready_d = 1'b0;
    fault_d     = 1'b0;
    unique case (state_d)
      PLL_RESET: begin
        pll_rst_n_d = 1'b0;
      end
      WAIT_LOCK, STABILIZE: begin
        pll_rst_n_d = 1'b1;
      end
      RUN: begin
        pll_rst_n_d = 1'b1;
        sys_rst_d   = 1'b0;
        clk_ready_d = 1'b1;
      end
      FAULT: begin
        pll_rst_n_d = 1'b0;
        fault_d     = 1'b1;
      end
      default: begin
        pll_rst_n_d = 1'b0;
      end
    endcase
  end

  assign pll_rst_n  = pll_rst_n_q;
  assign sys_rst    = sys_rst_q;
  assign clk_ready  = clk_ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer. A reference model predicts each
// change of the output bundle (with its edge number) and queues it; a
// monitor compares every observed output change against the queue head.
module tb_pll_lock_sequencer;

  localparam int RST_CY = 4;
  localparam int TO_CY  = 20;
  localparam int ST_CY  = 8;
  localparam int MAXR   = 2;
  localparam int SYNC   = 2;

  localparam int PH_HOLD   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       resequence = 1'b0;
  logic       pll_rst_n, sys_rst, clk_ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] relock_cnt;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (RST_CY),
    .LOCK_TIMEOUT_CYCLES (TO_CY),
    .LOCK_STABLE_CYCLES  (ST_CY),
    .MAX_RETRIES         (MAXR),
    .SYNC_STAGES         (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .resequence (resequence),
    .pll_rst_n  (pll_rst_n),
    .sys_rst    (sys_rst),
    .clk_ready  (clk_ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .relock_cnt (relock_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [13:0] outs;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model: a phase, a countdown of edges left in that phase, and
  // the queue of raw LOCK samples still in flight through the synchronizer.
  int m_phase   = PH_HOLD;
  int m_left    = RST_CY;
  int m_retries = 0;
  int m_relocks = 0;
  bit m_hist[$];

  function automatic void model_clear_hist();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step(input logic r, input logic lk, input logic rs);
    bit seen;
    if (r) begin
      m_phase = PH_HOLD; m_left = RST_CY; m_retries = 0; m_relocks = 0;
      model_clear_hist();
      return;
    end
    seen = m_hist.pop_front();
    m_hist.push_back(lk);
    if (rs) begin
      m_phase = PH_HOLD; m_left = RST_CY; m_retries = 0;
      return;
    end
    if (m_phase == PH_HOLD) begin
      m_left--;
      if (m_left == 0) begin m_phase = PH_WAIT; m_left = TO_CY; end
    end else if (m_phase == PH_WAIT) begin
      if (seen) begin
        m_phase = PH_SETTLE; m_left = ST_CY;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_retries == MAXR) m_phase = PH_FAULT;
          else begin m_retries++; m_phase = PH_HOLD; m_left = RST_CY; end
        end
      end
    end else if (m_phase == PH_SETTLE) begin
      if (!seen) begin
        m_phase = PH_WAIT; m_left = TO_CY;
      end else begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_RUN; m_retries = 0; end
      end
    end else if (m_phase == PH_RUN) begin
      if (!seen) begin
        m_phase = PH_HOLD; m_left = RST_CY;
        if (m_relocks < 255) m_relocks++;
      end
    end
  endfunction

  function automatic logic [13:0] model_outs();
    logic prn, srst, rdy, flt;
    prn  = (m_phase == PH_WAIT) || (m_phase == PH_SETTLE) || (m_phase == PH_RUN);
    srst = (m_phase != PH_RUN);
    rdy  = (m_phase == PH_RUN);
    flt  = (m_phase == PH_FAULT);
    return {prn, srst, rdy, flt, 2'(m_retries), 8'(m_relocks)};
  endfunction

  // Model advances on every active edge and queues each predicted change.
  initial begin
    logic [13:0] prev;
    logic [13:0] nxt;
    ev_t         e;
    prev = 'x;
    model_clear_hist();
    forever begin
      @(posedge clk);
      cyc++;
      model_step(rst, pll_locked, resequence);
      nxt = model_outs();
      if (nxt !== prev) begin
        e.cyc  = cyc;
        e.outs = nxt;
        exp_q.push_back(e);
        prev = nxt;
      end
    end
  end

  // Monitor: every change of the DUT output bundle is one transaction.
  initial begin
    logic [13:0] last;
    logic [13:0] now;
    ev_t         e;
    last = 'x;
    forever begin
      @(negedge clk);
      now = {pll_rst_n, sys_rst, clk_ready, fault, retry_cnt, relock_cnt};
      if (now !== last) begin
        last = now;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge %0d got outs=%h required no change", cyc, now);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.outs !== now) begin
            errors++;
            $display("FAIL output_event got edge %0d outs=%h required edge %0d outs=%h",
                     cyc, now, e.cyc, e.outs);
          end else begin
            $display("ev edge %0d prn=%b srst=%b rdy=%b flt=%b retry=%0d relock=%0d",
                     cyc, now[13], now[12], now[11], now[10], now[9:8], now[7:0]);
          end
        end
      end
    end
  end

  task automatic wait_phase(input int p, input int budget, input string what);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s got phase %0d required phase %0d", what, m_phase, p);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int n;
    rst = 1'b1; pll_locked = 1'b0; resequence = 1'b0;
    idle(3);

    // 1: normal bring-up, lock raised 6 cycles after reset release
    rst = 1'b0;
    idle(6);
    pll_locked = 1'b1;
    wait_phase(PH_RUN, 100, "bringup");
    idle(5);

    // 2: no lock at all -> three attempts then FAULT
    rst = 1'b1; pll_locked = 1'b0;
    idle(1);
    rst = 1'b0;
    wait_phase(PH_FAULT, 200, "fault");
    idle(10);

    // 5a: resequence leaves FAULT
    resequence = 1'b1;
    idle(1);
    resequence = 1'b0;
    idle(2);

    // 3: dropout in STABILIZE at cnt=5
    pll_locked = 1'b1;
    n = 0;
    while (!(m_phase == PH_SETTLE && m_left == ST_CY - 5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL timeout_settle5 got phase %0d required phase %0d", m_phase, PH_SETTLE);
    end
    pll_locked = 1'b0;
    idle(3);
    pll_locked = 1'b1;
    wait_phase(PH_RUN, 100, "relock");
    idle(4);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    idle(2);
    pll_locked = 1'b1;
    wait_phase(PH_HOLD, 20, "loss");
    wait_phase(PH_RUN, 100, "reseq");
    idle(3);

    // 5b: rst in the middle of STABILIZE
    wait_phase(PH_RUN, 10, "pre_rst");
    pll_locked = 1'b0;
    wait_phase(PH_HOLD, 20, "loss2");
    pll_locked = 1'b1;
    wait_phase(PH_SETTLE, 100, "settle");
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wait_phase(PH_RUN, 100, "after_rst");

    // Randomized mix of dropouts, long outages, restarts and resets
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin pll_locked = 1'b0; idle($urandom_range(1, 4)); pll_locked = 1'b1; end
        1: begin pll_locked = 1'b0; idle($urandom_range(10, 90)); pll_locked = 1'b1; end
        2: begin resequence = 1'b1; idle(1); resequence = 1'b0; end
        3: begin rst = 1'b1; idle($urandom_range(1, 2)); rst = 1'b0; end
        4: begin pll_locked = ($urandom_range(0, 1) == 1); end
        default: begin pll_locked = 1'b1; end
      endcase
      idle($urandom_range(1, 30));
    end
    pll_locked = 1'b1;
    resequence = 1'b1;
    idle(1);
    resequence = 1'b0;
    wait_phase(PH_RUN, 100, "pre_sat");

    // 6: 260 lock losses in RUN -> relock_cnt saturates at 255
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      wait_phase(PH_HOLD, 20, "sat_loss");
      idle($urandom_range(0, 2));
      pll_locked = 1'b1;
      wait_phase(PH_RUN, 100, "sat_run");
      idle($urandom_range(0, 3));
    end

    idle(12);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog got no finish required finish before 5ms");
    $fatal(1, "watchdog");
  end

endmodule
